// File: rtl/multi_blinker.sv
// Multi-channel blinker: each switch rising edge arms/disarms its channel, which then blinks with a shared half-period.
// Optional 2-flop switch synchronizer enabled by defining MULTI_BLINKER_SYNC_EN.
module multi_blinker #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  switch,
  input  logic [CNT_WIDTH-1:0] half_period,
  output logic [CHANNELS-1:0]  out,
  output logic [CHANNELS-1:0]  active
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [CHANNELS-1:0] edge_in;
  logic [CHANNELS-1:0] switch_q;
  logic [CHANNELS-1:0] switch_d;
  logic [CHANNELS-1:0] rise;

`ifdef MULTI_BLINKER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync1_d;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] sync2_d;

  always_comb begin
    sync1_d = switch;
    sync2_d = sync1_q;
  end

  // Reset to ones so a switch held high through reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign edge_in = sync2_q;
`else
  assign edge_in = switch;
`endif

  always_comb begin
    switch_d = edge_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_q <= '1;
    end else begin
      switch_q <= switch_d;
    end
  end

  assign rise = edge_in & ~switch_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [1:0]           state_q;
      logic [1:0]           state_d;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;

      // A switch edge outranks counter expiry; >= keeps the counter from wrapping when H drops.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_OFF: begin
            cnt_d = '0;
            if (rise[gi]) begin
              state_d = ST_HIGH;
            end
          end
          ST_HIGH, ST_LOW: begin
            if (rise[gi]) begin
              state_d = ST_OFF;
              cnt_d   = '0;
            end else if (cnt_q >= half_period) begin
              state_d = (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign out[gi]    = (state_q == ST_HIGH);
      assign active[gi] = (state_q != ST_OFF);
    end
  endgenerate

endmodule
